// File: rtl/uart_debug_int.sv
// Debug tap on the UART RX path: captures each frame on the rising edge of frame_valid and counts it.
// Define UART_DEBUG_PARITY_EN to build the even-parity checker, the sticky error flag and the error counter.
module uart_debug_int #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [8:0]       frame,
    input  logic             frame_valid,
    input  logic             clear,
    output logic [8:0]       debug_frame,
    output logic             debug_strobe,
    output logic [CNT_W-1:0] frame_count,
    output logic             parity_err,
    output logic [ERR_W-1:0] err_count
);

    function automatic logic frame_parity(input logic [8:0] f);
        return ^f;
    endfunction

    logic             valid_q;
    logic             capture_s;
    logic [8:0]       frame_q,  frame_d;
    logic             strobe_q, strobe_d;
    logic [CNT_W-1:0] count_q,  count_d;

    assign capture_s = frame_valid & ~valid_q;

    // Next-state for capture register, strobe and saturating frame counter.
    always_comb begin
        frame_d  = frame_q;
        strobe_d = capture_s;
        count_d  = count_q;
        if (capture_s) begin
            frame_d = frame;
        end else begin
            frame_d = frame_q;
        end
        if (clear) begin
            count_d = {CNT_W{1'b0}};
        end else if (capture_s && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Capture path state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            frame_q  <= 9'h000;
            strobe_q <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
        end else begin
            valid_q  <= frame_valid;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
        end
    end

`ifdef UART_DEBUG_PARITY_EN
    logic             perr_q, perr_d;
    logic [ERR_W-1:0] err_q,  err_d;

    // Sticky parity flag and saturating error counter; clear overrides a same-cycle error.
    always_comb begin
        perr_d = perr_q;
        err_d  = err_q;
        if (clear) begin
            perr_d = 1'b0;
            err_d  = {ERR_W{1'b0}};
        end else if (capture_s && frame_parity(frame)) begin
            perr_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) begin
                err_d = err_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_d = err_q;
            end
        end else begin
            perr_d = perr_q;
            err_d  = err_q;
        end
    end

    // Parity statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
            err_q  <= {ERR_W{1'b0}};
        end else begin
            perr_q <= perr_d;
            err_q  <= err_d;
        end
    end

    assign parity_err = perr_q;
    assign err_count  = err_q;
`else
    assign parity_err = 1'b0;
    assign err_count  = {ERR_W{1'b0}};
`endif

    assign debug_frame  = frame_q;
    assign debug_strobe = strobe_q;
    assign frame_count  = count_q;

endmodule

// File: tb/tb_uart_debug_int.sv
// Directed self-checking bench for uart_debug_int with a queue scoreboard of expected captured frames.
module tb_uart_debug_int;

    logic        clk;
    logic        rst;
    logic [8:0]  frame;
    logic        frame_valid;
    logic        clear;
    logic [8:0]  debug_frame;
    logic        debug_strobe;
    logic [15:0] frame_count;
    logic        parity_err;
    logic [7:0]  err_count;

    logic        fv4;
    logic        clear4;
    logic [8:0]  debug_frame4;
    logic        debug_strobe4;
    logic [3:0]  frame_count4;
    logic        parity_err4;
    logic [1:0]  err_count4;

    int n_checks;
    int n_fail;
    logic [8:0] exp_q[$];
    logic [8:0] exp_frame;

`ifdef UART_DEBUG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    uart_debug_int dut (
        .clk(clk), .rst(rst), .frame(frame), .frame_valid(frame_valid), .clear(clear),
        .debug_frame(debug_frame), .debug_strobe(debug_strobe), .frame_count(frame_count),
        .parity_err(parity_err), .err_count(err_count)
    );

    uart_debug_int #(.CNT_W(4), .ERR_W(2)) dut4 (
        .clk(clk), .rst(rst), .frame(frame), .frame_valid(fv4), .clear(clear4),
        .debug_frame(debug_frame4), .debug_strobe(debug_strobe4), .frame_count(frame_count4),
        .parity_err(parity_err4), .err_count(err_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pops the oldest expected frame when a strobe is seen and compares it.
    task automatic expect_capture(input string tag);
        check({tag, "_strobe"}, {31'd0, debug_strobe}, 32'd1);
        if (debug_strobe === 1'b1 && exp_q.size() > 0) begin
            exp_frame = exp_q.pop_front();
            check({tag, "_frame"}, {23'd0, debug_frame}, {23'd0, exp_frame});
        end else begin
            check({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd1);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        frame       = 9'h0AA;
        frame_valid = 1'b1;
        clear       = 1'b0;
        fv4         = 1'b0;
        clear4      = 1'b0;

        // Reset held with valid high: everything zero.
        tick(); tick(); tick();
        check("rst_frame",  {23'd0, debug_frame}, 32'h0);
        check("rst_strobe", {31'd0, debug_strobe}, 32'h0);
        check("rst_count",  {16'd0, frame_count}, 32'h0);
        check("rst_perr",   {31'd0, parity_err}, 32'h0);
        check("rst_err",    {24'd0, err_count}, 32'h0);

        // Release with valid already high: capture on the first edge.
        rst = 1'b1;
        exp_q.push_back(9'h0AA);
        tick();
        frame_valid = 1'b0;
        expect_capture("rel");
        check("rel_count", {16'd0, frame_count}, 32'd1);
        tick();
        check("rel_strobe_low", {31'd0, debug_strobe}, 32'd0);

        // Mid-operation reset discards a pending capture.
        frame = 9'h033;
        frame_valid = 1'b1;
        #2 rst = 1'b0;
        tick();
        frame_valid = 1'b0;
        check("midrst_strobe", {31'd0, debug_strobe}, 32'd0);
        check("midrst_count",  {16'd0, frame_count}, 32'd0);
        check("midrst_frame",  {23'd0, debug_frame}, 32'h0);
        rst = 1'b1;
        tick();

        // Good frame.
        frame = 9'b010101010;
        frame_valid = 1'b1;
        exp_q.push_back(9'h0AA);
        tick();
        frame_valid = 1'b0;
        expect_capture("good");
        check("good_count", {16'd0, frame_count}, 32'd1);
        check("good_perr",  {31'd0, parity_err}, 32'd0);
        check("good_err",   {24'd0, err_count}, 32'd0);
        tick();
        check("good_strobe_low", {31'd0, debug_strobe}, 32'd0);
        check("good_hold",       {23'd0, debug_frame}, 32'h0AA);

        // Bad-parity frame.
        frame = 9'b010110011;
        frame_valid = 1'b1;
        exp_q.push_back(9'h0B3);
        tick();
        frame_valid = 1'b0;
        expect_capture("bad");
        check("bad_count", {16'd0, frame_count}, 32'd2);
        check("bad_perr",  {31'd0, parity_err}, {31'd0, PAR});
        check("bad_err",   {24'd0, err_count}, {31'd0, PAR});
        tick();
        check("bad_perr_sticky", {31'd0, parity_err}, {31'd0, PAR});

        // Held valid with changing frame: one capture only.
        frame = 9'h0C3;
        frame_valid = 1'b1;
        exp_q.push_back(9'h0C3);
        tick();
        expect_capture("held");
        check("held_count", {16'd0, frame_count}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            frame = 9'h1FF - 9'(i);
            tick();
            check("held_strobe_low", {31'd0, debug_strobe}, 32'd0);
            check("held_frame",      {23'd0, debug_frame}, 32'h0C3);
            check("held_count_hold", {16'd0, frame_count}, 32'd3);
        end
        frame_valid = 1'b0;
        tick();

        // Clear coincident with a (bad-parity) capture.
        frame = 9'h155;
        frame_valid = 1'b1;
        clear = 1'b1;
        exp_q.push_back(9'h155);
        tick();
        frame_valid = 1'b0;
        clear = 1'b0;
        expect_capture("clr");
        check("clr_count", {16'd0, frame_count}, 32'd0);
        check("clr_err",   {24'd0, err_count}, 32'd0);
        check("clr_perr",  {31'd0, parity_err}, 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_keeps_frame", {23'd0, debug_frame}, 32'h155);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // Saturation on the narrow instance, using bad-parity frames.
        frame = 9'h0B3;
        for (int i = 1; i <= 20; i++) begin
            fv4 = 1'b1;
            tick();
            fv4 = 1'b0;
            check("sat_count", {28'd0, frame_count4}, (i > 15) ? 32'hF : 32'(i));
            tick();
        end
        check("sat_err",  {30'd0, err_count4}, PAR ? 32'd3 : 32'd0);
        check("sat_perr", {31'd0, parity_err4}, {31'd0, PAR});
        check("sat_wide_untouched", {16'd0, frame_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_debug_int.md
# uart_debug_int

Debug tap on the UART receive path. It captures every 9-bit frame the receiver presents, holds the most recent one on `debug_frame` for observation (LEDs, probe header, logic analyser), and counts frames. When compiled in, it also checks frame parity and accumulates error statistics. It sits beside the UART RX core and only observes it: it has no back-pressure and never stalls the receiver.

## Interface
Parameters:
- `CNT_W`, default 16: width of the frame counter.
- `ERR_W`, default 8: width of the parity-error counter.

Ports:
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `frame`  input  9  received frame; `frame[8]` is the parity bit, `frame[7:0]` is the data byte.
- `frame_valid`  input  1  frame-present qualifier from the RX core. May stay high for more than one cycle.
- `clear`  input  1  synchronous clear of the counters and sticky flags.
- `debug_frame`  output  9  last captured frame.
- `debug_strobe`  output  1  one-cycle pulse on each capture.
- `frame_count`  output  `CNT_W`  number of frames captured; saturating.
- `parity_err`  output  1  sticky parity-error flag (macro only).
- `err_count`  output  `ERR_W`  number of parity errors; saturating (macro only).

## Operation
- `valid_q` registers `frame_valid`. A capture event is `frame_valid & ~valid_q`, i.e. a rising edge of `frame_valid`.
  - A long high pulse on `frame_valid` produces exactly one capture.
  - `frame_valid` must return low for at least one sampled cycle before the next capture.
- On a capture event:
  - `debug_frame <= frame`.
  - `debug_strobe <= 1` for one cycle.
  - `frame_count` increments, saturating at all-ones.
- With no capture event, `debug_frame` holds its value and `debug_strobe` is 0.
- `frame` is sampled only on the capture cycle. Changes on `frame` at any other time are ignored.
- `clear`:
  - Zeroes `frame_count`, `err_count` and `parity_err`.
  - Does not alter `debug_frame`.
  - Clear and capture in the same cycle: clear wins for counters and flags, and the counters end at 0. `debug_frame` and `debug_strobe` still update.
- Parity is even over all 9 bits: a frame is good when `^frame == 0`.

## Timing
- Values after `rst` asserted (asynchronous):
  - `debug_frame` = 9'h000
  - `debug_strobe` = 0
  - `valid_q` = 0
  - `frame_count` = 0
  - `err_count` = 0
  - `parity_err` = 0
- Reset asserted mid-operation discards any pending capture.
- After reset release with `frame_valid` already high, a capture occurs on the first clock edge, because `valid_q` resets to 0.
- Latency: `debug_frame` and `debug_strobe` update on the first rising edge at which `frame_valid` is sampled 1 and `valid_q` is 0. `frame_count`, `err_count` and `parity_err` update on that same edge.
- `debug_strobe` is high for exactly one cycle per capture.
- `frame_valid` and `frame` must meet setup to `clk`. No internal synchroniser: the RX core is in the same clock domain.

## Configuration
- Macro: `UART_DEBUG_PARITY_EN`.
- Defined:
  - On a capture with `^frame == 1`, `parity_err` is set (sticky until `clear` or reset).
  - `err_count` increments, saturating.
- Undefined:
  - No parity logic is built.
  - `parity_err` is tied to 0 and `err_count` to 0.
  - Port list is unchanged.

## Test plan
- Reset: hold `rst=0` and drive `frame_valid=1` → all outputs 0. Release `rst` → capture on the first edge, `frame_count=1`.
- Good frame: `frame=9'b010101010`, `frame_valid` pulsed high for one cycle → `debug_frame=9'h0AA`, one-cycle `debug_strobe`, `frame_count=1`, `parity_err=0`.
- Bad frame: then `frame=9'b010110011` pulsed → `debug_frame=9'h0B3`, `frame_count=2`. With the macro: `parity_err=1`, `err_count=1`. Without the macro: both stay 0.
- Held valid: `frame_valid` high for 5 cycles while `frame` changes → a single capture of the value present on the first cycle, with `frame_count` +1 only.
- Clear: `clear=1` coincident with a capture of 9'h155 → `debug_frame=9'h155`, `debug_strobe=1`, and `frame_count`, `err_count`, `parity_err` all 0.
- Saturation: with `CNT_W=4`, apply 20 captures → `frame_count` stays at 4'hF.
